// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, lane masks and request checks for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  function automatic logic req_err(input logic ren, input logic wen, input logic [31:0] addr,
                                   input logic [3:0] mask, input int unsigned depth);
    return (ren & wen) | (|addr[1:0]) | ({2'b00, addr} >= (34'(depth) << 2)) | (mask == 4'h0);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-byte synchronous writes and a lane-masked registered read
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [3:0]    lanes,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);
  logic [31:0] mem [DEPTH_WORDS];
  // commit only the enabled byte lanes
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  // read port holds its value between reads; disabled lanes read as zero
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 32'h0;
    else if (re)
      for (int b = 0; b < 4; b++)
        q[8*b +: 8] <= lanes[b] ? mem[idx][8*b +: 8] : 8'h0;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency handshaked data memory serving one request at a time
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_busy,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end
  state_t state, state_n;
  logic [3:0] cnt, mask_r, cur_mask, we, lanes;
  logic [AW-1:0] idx_r, cur_idx;
  logic [31:0] wdata_r, cur_wdata;
  logic ren_r, wen_r, err_r, req, in_err, from_idle, cur_ren, cur_wen, cur_err, go, re;
  // next state; when LATENCY is 1 the RESP entry edge is the accept edge, so the array is fed from the live inputs
  always_comb begin
    req = i_dmem_ren | i_dmem_wen;
    in_err = req_err(i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_mask, DEPTH_WORDS);
    from_idle = state == IDLE;
    cur_idx = from_idle ? i_dmem_addr[AW+1:2] : idx_r;
    cur_wdata = from_idle ? i_dmem_wdata : wdata_r;
    cur_mask = from_idle ? i_dmem_mask : mask_r;
    cur_ren = from_idle ? i_dmem_ren : ren_r;
    cur_wen = from_idle ? i_dmem_wen : wen_r;
    cur_err = from_idle ? in_err : err_r;
    state_n = state == IDLE ? (req ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    go = i_rst_n && state_n == RESP && state != RESP;
    we = go && cur_wen && !cur_err ? cur_mask : 4'h0;
    re = go && (cur_ren || cur_err);
    lanes = cur_err ? 4'h0 : cur_mask;
  end
  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  // capture the accepted request and count down the remaining wait cycles
  always_ff @(posedge i_clk) begin
    if (from_idle && req) begin
      idx_r <= i_dmem_addr[AW+1:2];
      wdata_r <= i_dmem_wdata;
      mask_r <= i_dmem_mask;
      ren_r <= i_dmem_ren;
      wen_r <= i_dmem_wen;
      err_r <= in_err;
    end
    cnt <= state == IDLE ? 4'(LATENCY - 1) : state == WAIT ? cnt - 4'd1 : cnt;
  end
  assign o_dmem_busy = state != IDLE;
  assign o_dmem_valid = state == RESP;
  assign o_dmem_err = o_dmem_valid & err_r;
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .we(we),
    .re(re),
    .lanes(lanes),
    .idx(cur_idx),
    .wdata(cur_wdata),
    .q(o_dmem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for the fixed-latency data memory responder
module tb_dmem_responder;
  localparam int L2 = 2;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2, ren2, wen2, busy2, valid2, err2;
  logic [31:0] addr2, wdata2, rdata2;
  logic [3:0] mask2;
  logic rst1, ren1, wen1, busy1, valid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0] mask1;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_push = 0;
  logic [31:0] cyc = 0;
  exp_t q[$];
  exp_t em;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(L2)) u2 (
    .i_clk(clk), .i_rst_n(rst2), .i_dmem_addr(addr2), .i_dmem_ren(ren2), .i_dmem_wen(wen2),
    .i_dmem_wdata(wdata2), .i_dmem_mask(mask2), .o_dmem_busy(busy2), .o_dmem_valid(valid2),
    .o_dmem_rdata(rdata2), .o_dmem_err(err2)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
    .i_clk(clk), .i_rst_n(rst1), .i_dmem_addr(addr1), .i_dmem_ren(ren1), .i_dmem_wen(wen1),
    .i_dmem_wdata(wdata1), .i_dmem_mask(mask1), .o_dmem_busy(busy1), .o_dmem_valid(valid1),
    .o_dmem_rdata(rdata1), .o_dmem_err(err1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // monitor: every response strobe is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid2) begin
      n_valid++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid got 1 exp 0 at cycle %0d", cyc);
      end else begin
        em = q.pop_front();
        chk("rsp_rdata", rdata2, em.rdata);
        chk("rsp_err", {31'b0, err2}, {31'b0, em.err});
        chk("rsp_latency", cyc, em.cyc);
      end
    end
  end

  task automatic idle_wait();
    int n = 0;
    while (busy2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait got busy 1 exp 0");
    end
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] er, input logic ee);
    exp_t e;
    idle_wait();
    ren2 = r; wen2 = w; addr2 = a; wdata2 = d; mask2 = m;
    @(posedge clk);
    e.rdata = er;
    e.err = ee;
    e.cyc = cyc + L2;
    q.push_back(e);
    n_push++;
    @(negedge clk);
    ren2 = 1'b0; wen2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst2 = 0; ren2 = 0; wen2 = 0; addr2 = 0; wdata2 = 0; mask2 = 0;
    rst1 = 0; ren1 = 0; wen1 = 0; addr1 = 0; wdata1 = 0; mask1 = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy2}, 0);
    chk("reset_valid", {31'b0, valid2}, 0);
    chk("reset_rdata", rdata2, 0);
    chk("reset_err", {31'b0, err2}, 0);
    rst2 = 1; rst1 = 1;
    @(negedge clk);
    // LATENCY=1 instance: write, then a read request held continuously
    wen1 = 1; addr1 = 32'h0; wdata1 = 32'h12345678; mask1 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("l1_wr_valid", {31'b0, valid1}, 1);
    chk("l1_wr_err", {31'b0, err1}, 0);
    wen1 = 0; ren1 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l1_valid", {31'b0, valid1}, i % 2);
      chk("l1_busy", {31'b0, busy1}, i % 2);
      chk("l1_rdata", rdata1, i == 0 ? 32'h0 : 32'h12345678);
    end
    ren1 = 0;
    // LATENCY=2 instance: data path, lane merging and error responses
    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
    issue(0, 1, 32'h10, 32'h00AA0000, 4'h4, 32'hDEADBEEF, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 0);
    issue(1, 0, 32'h10, 32'h0, 4'hC, 32'hDEAA0000, 0);
    issue(1, 1, 32'h10, 32'h0, 4'hF, 32'h0, 1);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 0);
    issue(1, 0, 32'h12, 32'h0, 4'hF, 32'h0, 1);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 0);
    issue(1, 0, 32'h1000, 32'h0, 4'hF, 32'h0, 1);
    issue(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
    issue(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 0);
    // a second read presented while busy must be dropped
    issue(1, 0, 32'h10, 32'h0, 4'h3, 32'h0000BEEF, 0);
    ren2 = 1; addr2 = 32'h20; mask2 = 4'hF;
    chk("drop_busy_wait", {31'b0, busy2}, 1);
    @(negedge clk);
    chk("drop_busy_resp", {31'b0, busy2}, 1);
    @(negedge clk);
    chk("drop_busy_idle", {31'b0, busy2}, 0);
    ren2 = 0;
    repeat (4) @(negedge clk);
    chk("drop_busy_after", {31'b0, busy2}, 0);
    // reset during WAIT of a write discards it
    issue(0, 1, 32'h20, 32'h11111111, 4'hF, 32'h0000BEEF, 0);
    idle_wait();
    wen2 = 1; addr2 = 32'h20; wdata2 = 32'h22222222; mask2 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy2}, 1);
    chk("rst_mid_valid", {31'b0, valid2}, 0);
    rst2 = 0; wen2 = 0;
    @(negedge clk);
    chk("rst_after_busy", {31'b0, busy2}, 0);
    chk("rst_after_valid", {31'b0, valid2}, 0);
    chk("rst_after_rdata", rdata2, 0);
    chk("rst_after_err", {31'b0, err2}, 0);
    rst2 = 1;
    @(negedge clk);
    issue(1, 0, 32'h20, 32'h0, 4'hF, 32'h11111111, 0);
    idle_wait();
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("valid_pulses", n_valid, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the hart's data memory port: accepts the same address / read-enable / write-enable / write-data / byte-mask request the hart drives, and services it from an internal word array after a fixed, parameterised latency. It replaces the ideal combinational data memory of phase 3 with a multi-cycle, handshaked memory that the pipeline must stall on. It sits outside the hart, between the hart's dmem port and the testbench.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..15.
- i_clk  in  1  global clock.
- i_rst_n  in  1  reset; one clock, synchronous and active-low.
- i_dmem_addr  in  32  byte address of the request; must be word aligned.
- i_dmem_ren  in  1  read request.
- i_dmem_wen  in  1  write request.
- i_dmem_wdata  in  32  write data, already placed in its byte lanes.
- i_dmem_mask  in  4  byte-lane enables; bit n selects bits 8n+7:8n.
- o_dmem_busy  out  1  request in flight; new requests are ignored.
- o_dmem_valid  out  1  one-cycle response strobe.
- o_dmem_rdata  out  32  read data; masked bytes valid, unmasked bytes forced to 0.
- o_dmem_err  out  1  error qualifier, valid only with o_dmem_valid.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on a rising edge with (i_dmem_ren | i_dmem_wen) = 1, the request is accepted.
  - Latch addr, wdata, mask and the op type.
  - Load the counter with LATENCY-1.
  - Go to WAIT, or go directly to RESP if LATENCY = 1.
- WAIT: decrement the counter each cycle. When the counter reaches 0, take the RESP transition at the next edge.
- RESP: o_dmem_valid = 1 for exactly one cycle, then return to IDLE.
- Effects on the edge entering RESP:
  - Write: masked bytes are committed to the array; unmasked bytes are untouched.
  - Read: the array word is registered into o_dmem_rdata with unmasked lanes zeroed.
- o_dmem_rdata holds its value until the next read response. Writes do not update it.
- Error cases: o_dmem_err = 1 during RESP, with no array write and o_dmem_rdata = 0, when any of these hold:
  - ren and wen are both high at acceptance;
  - addr[1:0] != 0;
  - addr >= 4*DEPTH_WORDS;
  - mask = 0.
  An error response still consumes the full LATENCY.
- The index is computed as addr[31:2]. Upper bits beyond log2(DEPTH_WORDS) participate only in the range check; there is no wrap-around.
- The array has no reset. Contents are undefined at power-up unless preloaded by the bench hierarchically.

## Timing
- Output values while i_rst_n = 0: o_dmem_busy=0, o_dmem_valid=0, o_dmem_rdata=0, o_dmem_err=0; state IDLE.
- o_dmem_busy = 1 in WAIT and RESP, and 0 only in IDLE.
- Request at edge e0 → o_dmem_valid high in the cycle after edge e0+LATENCY-1 (i.e. LATENCY cycles after e0).
- Throughput: one request per LATENCY+1 cycles.
- Requests presented while busy are dropped silently. The requester must hold them until o_dmem_busy = 0.
- Reset asserted mid-operation (WAIT or RESP) discards the in-flight request. A pending write is not committed unless its RESP entry edge has already occurred.
- A read accepted after a write's RESP returns the written data (read-after-write coherent).

## Structure
- Package dmem_pkg holds:
  - the state typedef (IDLE/WAIT/RESP);
  - MASK_WORD=4'b1111, MASK_HALF_LO=4'b0011, MASK_HALF_HI=4'b1100;
  - the LATENCY range constants.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage;
  - synchronous per-byte write enables;
  - synchronous registered read.
- The FSM, counter and error logic stay in dmem_responder.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 with mask 1111 → valid two cycles after each accept; rdata=0xDEADBEEF; err=0.
- After that, write 0x00AA0000 to 0x10 with mask 0100, then read with mask 1111 → rdata=0xDEAABEEF. Read with mask 1100 → rdata=0xDEAA0000.
- Error paths, each → err=1 with valid after LATENCY and rdata=0; then a read of 0x10 returns unchanged data:
  - ren and wen both high at addr 0x10;
  - addr 0x12;
  - addr 4*DEPTH_WORDS.
- Issue a second read while busy=1 → it is ignored: exactly one valid pulse, busy stays high until RESP ends.
- LATENCY=1, back-to-back requests held continuously → valid every second cycle; busy toggles 1/0.
- Assert i_rst_n=0 during WAIT of a write to 0x20 (prior value 0x11111111) → all outputs 0 next cycle; a later read of 0x20 returns 0x11111111.
